// File: rtl/serial_pkg.sv
// serial_pkg: shared state encoding and sizing helpers for the serial
// transmit arbiter.
package serial_pkg;

  // Arbiter phases for one granted message.
  typedef enum logic [2:0] {
    sIdle   = 3'd0,
    sAccept = 3'd1,
    sSend   = 3'd2,
    sHold   = 3'd3,
    sGap    = 3'd4
  } state_e;

  // One counter serves both the inter-message gap and the stall timeout,
  // so it must hold the larger of the two terminal counts.
  function automatic int cnt_width(input int gap_ticks, input int stall_ticks);
    int span;
    span = (gap_ticks > stall_ticks) ? gap_ticks : stall_ticks;
    return $clog2(span + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector. Returns the one-hot position
// of the first asserted request at or above ptr, wrapping past the top.
module rr_pick #(
  parameter int Requesters = 4,
  parameter int IdxW       = $clog2(Requesters)
) (
  input  logic [Requesters-1:0] req,
  input  logic [IdxW-1:0]       ptr,
  output logic [Requesters-1:0] winner
);

  localparam logic [Requesters-1:0] One = Requesters'(1);

  // Scan from the farthest offset back to the pointer so the nearest request wins.
  always_comb begin
    int idx;
    logic [Requesters-1:0] mask;
    // NOTE: every variable gets a value before any branch so no latch is inferred.
    winner = '0;
    idx    = 0;
    mask   = '0;
    for (int off = Requesters - 1; off >= 0; off--) begin
      idx = int'(ptr) + off;
      if (idx >= Requesters) idx = idx - Requesters;
      mask = One << idx;
      if ((req & mask) != '0) winner = mask;
    end
  end

endmodule

// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: grants one requester at a time and forwards its message
// byte by byte to a single serial transmitter, with an idle gap between
// messages and an abort when the owner stalls too long.
module serial_tx_arbiter
  import serial_pkg::*;
#(
  parameter int Requesters = 4,
  parameter int GapTicks   = 16,
  parameter int StallTicks = 1024
) (
  input  logic                    iClock,
  input  logic                    iReset,
  input  logic [Requesters-1:0]   iReqValid,
  input  logic [8*Requesters-1:0] iReqData,
  input  logic [Requesters-1:0]   iReqLast,
  output logic [Requesters-1:0]   oReqReady,
  output logic [Requesters-1:0]   oGrant,
  output logic                    oTxSend,
  output logic [7:0]              oTxData,
  input  logic                    iTxReady,
  output logic                    oAbort
);

  localparam int IdxW = $clog2(Requesters);
  localparam int CntW = cnt_width(GapTicks, StallTicks);
  localparam logic [CntW-1:0] StallLast = CntW'(StallTicks - 1);
  localparam logic [CntW-1:0] GapLast   = CntW'((GapTicks > 0) ? GapTicks - 1 : 0);
  localparam logic [IdxW-1:0] TopIdx    = IdxW'(Requesters - 1);

  state_e                state_q, state_d;
  logic [IdxW-1:0]       ptr_q, ptr_d;
  logic [Requesters-1:0] grant_q, grant_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  last_q, last_d;
  logic                  send_q, send_d;
  logic                  abort_q, abort_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  logic [Requesters-1:0] pick;
  logic [IdxW-1:0]       owner_idx;
  logic [IdxW-1:0]       next_ptr;
  logic                  owner_valid;
  logic [7:0]            owner_data;
  logic                  owner_last;
  state_e                leave_state;

  rr_pick #(
    .Requesters(Requesters),
    .IdxW      (IdxW)
  ) u_rr_pick (
    .req   (iReqValid),
    .ptr   (ptr_q),
    .winner(pick)
  );

  // Decode the registered one-hot grant into the owner's index and request lanes.
  always_comb begin
    owner_idx   = '0;
    owner_valid = 1'b0;
    owner_data  = '0;
    owner_last  = 1'b0;
    for (int k = 0; k < Requesters; k++) begin
      if (grant_q[k]) begin
        owner_idx   = IdxW'(k);
        owner_valid = iReqValid[k];
        owner_data  = iReqData[8*k +: 8];
        owner_last  = iReqLast[k];
      end
    end
  end

  // Fairness pointer moves just past the owner whenever a message is left.
  assign next_ptr    = (owner_idx == TopIdx) ? '0 : owner_idx + 1'b1;
  assign leave_state = (GapTicks == 0) ? sIdle : sGap;

  // Only the owner sees ready, and only while the transmitter is idle.
  assign oReqReady = (state_q == sAccept && !iReset) ? (grant_q & {Requesters{iTxReady}}) : '0;
  assign oGrant    = grant_q;
  assign oTxSend   = send_q;
  assign oTxData   = tx_data_q;
  assign oAbort    = abort_q;

  // Next-state logic: arbitration, byte handoff, stall timeout and gap timing.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    tx_data_d = tx_data_q;
    last_d    = last_q;
    send_d    = 1'b0;
    abort_d   = 1'b0;
    cnt_d     = cnt_q;
    case (state_q)
      sIdle: begin
        if (|iReqValid) begin
          grant_d = pick;
          cnt_d   = '0;
          state_d = sAccept;
        end
      end
      sAccept: begin
        if (iTxReady) begin
          if (owner_valid) begin
            tx_data_d = owner_data;
            last_d    = owner_last;
            cnt_d     = '0;
            send_d    = 1'b1;
            state_d   = sSend;
          end else if (cnt_q == StallLast) begin
            abort_d = 1'b1;
            grant_d = '0;
            ptr_d   = next_ptr;
            cnt_d   = '0;
            state_d = leave_state;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      sSend: state_d = sHold;
      sHold: begin
        if (!last_q) begin
          state_d = sAccept;
        end else begin
          grant_d = '0;
          ptr_d   = next_ptr;
          cnt_d   = '0;
          state_d = leave_state;
        end
      end
      sGap: begin
        if (cnt_q == GapLast) begin
          cnt_d   = '0;
          state_d = sIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = sIdle;
    endcase
  end

  // State and registered outputs; reset abandons any message silently.
  always_ff @(posedge iClock) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (iReset) begin
      state_q   <= sIdle;
      ptr_q     <= '0;
      grant_q   <= '0;
      tx_data_q <= '0;
      last_q    <= 1'b0;
      send_q    <= 1'b0;
      abort_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      tx_data_q <= tx_data_d;
      last_q    <= last_d;
      send_q    <= send_d;
      abort_q   <= abort_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb_serial_tx_arbiter: directed and randomized stimulus checked every cycle
// against a timeline model of the arbiter built from its message rules.
module tb_serial_tx_arbiter;

  localparam int R       = 4;
  localparam int GAP     = 2;
  localparam int STALL   = 8;
  localparam int TX_BUSY = 10;
  localparam int NEVER   = 32'h7fff_ffff;

  logic           clk = 1'b0;
  logic           iReset = 1'b1;
  logic [R-1:0]   iReqValid = '0;
  logic [8*R-1:0] iReqData = '0;
  logic [R-1:0]   iReqLast = '0;
  logic [R-1:0]   oReqReady;
  logic [R-1:0]   oGrant;
  logic           oTxSend;
  logic [7:0]     oTxData;
  logic           iTxReady = 1'b1;
  logic           oAbort;

  always #5 clk = ~clk;

  serial_tx_arbiter #(
    .Requesters(R),
    .GapTicks  (GAP),
    .StallTicks(STALL)
  ) dut (
    .iClock   (clk),
    .iReset   (iReset),
    .iReqValid(iReqValid),
    .iReqData (iReqData),
    .iReqLast (iReqLast),
    .oReqReady(oReqReady),
    .oGrant   (oGrant),
    .oTxSend  (oTxSend),
    .oTxData  (oTxData),
    .iTxReady (iTxReady),
    .oAbort   (oAbort)
  );

  // Requester environment: per-requester byte queues ({last, data}).
  logic [8:0] msg_q [R][$];
  int hold_off [R];
  int stall_after [R];
  int tx_busy = 0;

  // Timeline model: cycle numbers at which each observable event must occur.
  int m_owner = -1;
  int m_ptr = 0;
  int m_accept_from = NEVER;
  int m_idle_from = 0;
  int m_stall = 0;
  int m_send_at = -1;
  int m_abort_at = -1;
  int m_release_at = -1;
  int m_started = 0;
  int m_xfer = 0;
  logic [7:0] m_txdata = '0;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  logic [R-1:0] grant_log[$];
  logic [7:0]   sent_log[$];
  logic [R-1:0] prev_grant = '0;
  int abort_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int rr_model(input logic [R-1:0] v, input int ptr);
    for (int i = 0; i < R; i++) begin
      int k;
      k = (ptr + i) % R;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic all_empty();
    for (int k = 0; k < R; k++) if (msg_q[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Requester abandons the rest of its current message.
  task automatic drop_message(input int k);
    logic [8:0] e;
    while (msg_q[k].size() > 0) begin
      e = msg_q[k].pop_front();
      if (e[8]) break;
    end
  endtask

  task automatic push_msg(input int k, input int len);
    for (int i = 0; i < len; i++) msg_q[k].push_back({(i == len - 1) ? 1'b1 : 1'b0, 8'($urandom)});
  endtask

  task automatic model_step(input logic rst, input logic [R-1:0] v, input logic tr);
    logic [8:0] e;
    if (rst) begin
      if (m_owner >= 0 && m_started != 0) drop_message(m_owner);
      m_owner = -1; m_ptr = 0; m_idle_from = cyc + 1; m_send_at = -1; m_abort_at = -1;
      m_release_at = -1; m_txdata = '0; m_stall = 0; m_accept_from = NEVER; m_started = 0;
      return;
    end
    if (m_owner < 0) begin
      if (cyc >= m_idle_from && v != '0) begin
        m_owner = rr_model(v, m_ptr);
        m_accept_from = cyc + 1;
        m_stall = 0;
        m_started = 0;
      end
    end else if (cyc >= m_accept_from && tr) begin
      if (v[m_owner]) begin
        e = msg_q[m_owner].pop_front();
        m_txdata = e[7:0];
        m_send_at = cyc + 1;
        m_stall = 0;
        m_started = 1;
        m_xfer++;
        if (stall_after[m_owner] > 0) begin
          hold_off[m_owner] = stall_after[m_owner];
          stall_after[m_owner] = 0;
        end
        if (e[8]) begin
          m_release_at = cyc + 3;
          m_idle_from = cyc + 3 + GAP;
          m_ptr = (m_owner + 1) % R;
          m_accept_from = NEVER;
          m_started = 0;
        end else begin
          m_accept_from = cyc + 3;
        end
      end else begin
        m_stall++;
        if (m_stall == STALL) begin
          m_abort_at = cyc + 1;
          drop_message(m_owner);
          m_ptr = (m_owner + 1) % R;
          m_idle_from = cyc + 1 + GAP;
          m_owner = -1;
          m_accept_from = NEVER;
          m_stall = 0;
          m_started = 0;
        end
      end
    end
    if (m_release_at == cyc + 1) m_owner = -1;
  endtask

  // One clock: drive at negedge, compare 1ns later, then advance model/environment.
  task automatic cycle(input logic rst);
    logic [R-1:0] v, eg, er;
    logic tr;
    @(negedge clk);
    tr = (tx_busy == 0);
    for (int k = 0; k < R; k++) begin
      v[k] = (msg_q[k].size() > 0) && (hold_off[k] == 0);
      if (v[k]) begin
        iReqData[8*k +: 8] = msg_q[k][0][7:0];
        iReqLast[k] = msg_q[k][0][8];
      end else begin
        iReqData[8*k +: 8] = 8'($urandom);
        iReqLast[k] = 1'($urandom);
      end
    end
    iReqValid = v;
    iTxReady = tr;
    iReset = rst;
    #1;
    eg = '0;
    er = '0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      if (!rst && tr && cyc >= m_accept_from) er[m_owner] = 1'b1;
    end
    if (cyc > 0) begin
      check("grant", oGrant, eg);
      check("ready", oReqReady, er);
      check("tx_send", oTxSend, cyc == m_send_at);
      check("abort", oAbort, cyc == m_abort_at);
      check("tx_data", oTxData, m_txdata);
    end
    if (oGrant != '0 && prev_grant == '0) grant_log.push_back(oGrant);
    prev_grant = oGrant;
    if (oTxSend === 1'b1) begin
      sent_log.push_back(oTxData);
      tx_busy = TX_BUSY;
    end else if (tx_busy > 0) begin
      tx_busy--;
    end
    if (oAbort === 1'b1) abort_cnt++;
    model_step(rst, v, tr);
    for (int k = 0; k < R; k++) if (hold_off[k] > 0) hold_off[k]--;
    cyc++;
  endtask

  task automatic drain();
    logic quiet;
    quiet = 1'b0;
    for (int i = 0; i < 3000 && !quiet; i++) begin
      cycle(1'b0);
      quiet = (m_owner < 0) && (cyc > m_idle_from) && all_empty() && (cyc > m_send_at) && (cyc > m_abort_at);
    end
    check("drain", quiet, 1'b1);
  endtask

  task automatic clear_env();
    for (int k = 0; k < R; k++) begin
      msg_q[k].delete();
      hold_off[k] = 0;
      stall_after[k] = 0;
    end
    grant_log.delete();
    sent_log.delete();
    abort_cnt = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_grant"}, oGrant, 0);
    check({tag, "_ready"}, oReqReady, 0);
    check({tag, "_send"}, oTxSend, 0);
    check({tag, "_abort"}, oAbort, 0);
    check({tag, "_data"}, oTxData, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int x0;
    clear_env();

    // Reset state.
    cycle(1'b1);
    cycle(1'b0);
    check_idle_outputs("reset");

    // Single three-byte message from requester 0.
    clear_env();
    cycle(1'b1);
    msg_q[0].push_back(9'h011);
    msg_q[0].push_back(9'h022);
    msg_q[0].push_back(9'h133);
    drain();
    check("s1_bytes", sent_log.size(), 3);
    if (sent_log.size() == 3) begin
      check("s1_b0", sent_log[0], 8'h11);
      check("s1_b1", sent_log[1], 8'h22);
      check("s1_b2", sent_log[2], 8'h33);
    end
    check("s1_grants", grant_log.size(), 1);
    if (grant_log.size() == 1) check("s1_g0", grant_log[0], 4'b0001);

    // Requesters 1 and 3 together: 1 finishes its message before 3 starts.
    clear_env();
    cycle(1'b1);
    msg_q[1].push_back(9'h0A1);
    msg_q[1].push_back(9'h1A2);
    msg_q[3].push_back(9'h0B1);
    msg_q[3].push_back(9'h1B2);
    drain();
    check("s2_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("s2_g0", grant_log[0], 4'b0010);
      check("s2_g1", grant_log[1], 4'b1000);
    end
    check("s2_bytes", sent_log.size(), 4);
    if (sent_log.size() == 4) begin
      check("s2_b0", sent_log[0], 8'hA1);
      check("s2_b1", sent_log[1], 8'hA2);
      check("s2_b2", sent_log[2], 8'hB1);
      check("s2_b3", sent_log[3], 8'hB2);
    end

    // Requester 2 streams one-byte messages; requester 0 arrives later.
    clear_env();
    cycle(1'b1);
    msg_q[2].push_back(9'h121);
    msg_q[2].push_back(9'h122);
    msg_q[2].push_back(9'h123);
    for (int i = 0; i < 3; i++) cycle(1'b0);
    msg_q[0].push_back(9'h101);
    drain();
    check("s3_grants", grant_log.size(), 4);
    if (grant_log.size() >= 3) begin
      check("s3_g0", grant_log[0], 4'b0100);
      check("s3_g1", grant_log[1], 4'b0001);
      check("s3_g2", grant_log[2], 4'b0100);
    end

    // Owner stalls after its first byte: abort, then requester 1 is served.
    clear_env();
    cycle(1'b1);
    msg_q[0].push_back(9'h001);
    msg_q[0].push_back(9'h002);
    msg_q[0].push_back(9'h103);
    stall_after[0] = 40;
    msg_q[1].push_back(9'h1C5);
    drain();
    check("s4_aborts", abort_cnt, 1);
    check("s4_bytes", sent_log.size(), 2);
    if (sent_log.size() == 2) check("s4_b1", sent_log[1], 8'hC5);
    check("s4_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) check("s4_g1", grant_log[1], 4'b0010);

    // Reset during the hold of byte 2; arbitration restarts from requester 0.
    clear_env();
    cycle(1'b1);
    msg_q[1].push_back(9'h1D1);
    drain();
    msg_q[2].push_back(9'h0E1);
    msg_q[2].push_back(9'h0E2);
    msg_q[2].push_back(9'h1E3);
    x0 = m_xfer;
    for (int i = 0; i < 200 && m_xfer < x0 + 2; i++) cycle(1'b0);
    check("s5_reach", m_xfer, x0 + 2);
    cycle(1'b0);
    cycle(1'b1);
    grant_log.delete();
    abort_cnt = 0;
    msg_q[0].push_back(9'h1F0);
    msg_q[3].push_back(9'h1F3);
    cycle(1'b0);
    check_idle_outputs("s5_after_reset");
    drain();
    check("s5_aborts", abort_cnt, 0);
    check("s5_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("s5_g0", grant_log[0], 4'b0001);
      check("s5_g1", grant_log[1], 4'b1000);
    end

    // Randomized traffic with stalls and occasional resets.
    clear_env();
    cycle(1'b1);
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        int k;
        k = $urandom_range(0, R - 1);
        if (msg_q[k].size() < 6) push_msg(k, $urandom_range(1, 4));
        if ($urandom_range(0, 5) == 0) stall_after[k] = $urandom_range(1, 40);
      end
      cycle($urandom_range(0, 799) == 0);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
